// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline hazard unit with multi-cycle (mul/div) EX support.
//   Forwarding : ForwardAE/ForwardBE select the ALU operand source
//                (00 register file, 10 MEM result, 01 WB result).
//   Stalls     : StallF/StallD on a load-use hazard or a multi-cycle stall;
//                StallE only during a multi-cycle stall.
//   Flushes    : FlushD on a taken branch; FlushE on a load-use bubble or a
//                taken branch; FlushM while a multi-cycle op holds EX.
//   MdBusy     : a multi-cycle op is holding EX this cycle.
//   StallCount : saturating count of clock edges with StallF high.
// clk is the sole clock; reset is asynchronous and active-high.
module hazard_unit_mc #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              PCSrcE,
  input  logic              ResultSrcEb0,
  input  logic              MdStartE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int unsigned     MC_W    = $clog2(MD_LAT) + 1;
  localparam logic [MC_W-1:0] MD_LAST = MC_W'(MD_LAT - 1);
  localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [MC_W-1:0]  mdcnt_q, mdcnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             lw_stall;
  logic             md_stall;
  logic             stall_fd;

  // Operand forwarding; MEM is checked first so the younger result wins.
  always_comb begin
    ForwardAE = 2'b00;
    if (Rs1E != '0 && Rs1E == RdM && RegWriteM)      ForwardAE = 2'b10;
    else if (Rs1E != '0 && Rs1E == RdW && RegWriteW) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (Rs2E != '0 && Rs2E == RdM && RegWriteM)      ForwardBE = 2'b10;
    else if (Rs2E != '0 && Rs2E == RdW && RegWriteW) ForwardBE = 2'b01;
  end

  always_comb begin
    lw_stall = ResultSrcEb0 && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
    // The last occupancy cycle (mdcnt == MD_LAT-1) is the release cycle.
    md_stall = MdStartE && (mdcnt_q != MD_LAST);
    stall_fd = lw_stall || md_stall;

    StallF = stall_fd;
    StallD = stall_fd;
    StallE = md_stall;
    MdBusy = md_stall;
    FlushD = PCSrcE;
    // A load-use bubble is suppressed while EX is held; it re-evaluates
    // once the multi-cycle op releases.
    FlushE = (lw_stall && !md_stall) || PCSrcE;
    FlushM = md_stall;
  end

  always_comb begin
    mdcnt_d = '0;
    if (PCSrcE)        mdcnt_d = '0;
    else if (md_stall) mdcnt_d = mdcnt_q + MC_ONE;

    stall_count_d = stall_count_q;
    if (stall_fd && stall_count_q != '1) stall_count_d = stall_count_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdcnt_q       <= '0;
      stall_count_q <= '0;
    end else begin
      mdcnt_q       <= mdcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic PCSrcE, ResultSrcEb0, MdStartE, RegWriteM, RegWriteW;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
  logic [31:0] StallCount;

  logic [1:0]  s_fa, s_fb;
  logic        s_sf, s_sd, s_se, s_fd, s_fe, s_fm, s_busy;
  logic [3:0]  s_sc;

  logic [1:0]  l_fa, l_fb;
  logic        l_sf, l_sd, l_se, l_fd, l_fe, l_fm, l_busy;
  logic [31:0] l_sc;

  hazard_unit_mc dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcEb0(ResultSrcEb0),
    .MdStartE(MdStartE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy), .StallCount(StallCount)
  );

  hazard_unit_mc #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcEb0(ResultSrcEb0),
    .MdStartE(MdStartE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd),
    .StallE(s_se), .FlushD(s_fd), .FlushE(s_fe), .FlushM(s_fm),
    .MdBusy(s_busy), .StallCount(s_sc)
  );

  hazard_unit_mc #(.MD_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcEb0(ResultSrcEb0),
    .MdStartE(MdStartE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAE(l_fa), .ForwardBE(l_fb), .StallF(l_sf), .StallD(l_sd),
    .StallE(l_se), .FlushD(l_fd), .FlushE(l_fe), .FlushM(l_fm),
    .MdBusy(l_busy), .StallCount(l_sc)
  );

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic pc, ld, md, rwm, rww;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm, busy;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned exp_sc = 0;
  int unsigned exp_ssc = 0;
  bit chk_sat = 0;
  bit chk_l1 = 0;
  exp_t sb[$];

  function automatic in_t mk_in(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input logic pc, ld, md, rwm, rww);
    return {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, pc, ld, md, rwm, rww};
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] fa, fb,
                                  input logic sf, se, fd, fe, fm, busy);
    return {fa, fb, sf, sf, se, fd, fe, fm, busy};
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic apply(input string name, input in_t i, input exp_t e);
    exp_t a, r;
    @(negedge clk);
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, PCSrcE, ResultSrcEb0, MdStartE,
     RegWriteM, RegWriteW} = i;
    sb.push_back(e);
    #1;
    a = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy};
    r = sb.pop_front();
    n_vec++;
    if (a !== r) begin
      n_bad++;
      $display("FAIL %s: got fa,fb,sf,sd,se,fd,fe,fm,busy=%b_%b_%b%b%b%b%b%b%b, expected %b_%b_%b%b%b%b%b%b%b",
               name, a.fa, a.fb, a.sf, a.sd, a.se, a.fd, a.fe, a.fm, a.busy,
               r.fa, r.fb, r.sf, r.sd, r.se, r.fd, r.fe, r.fm, r.busy);
    end
    check_val({name, "_cnt"}, StallCount, exp_sc);
    if (chk_sat) check_val({name, "_satcnt"}, s_sc, exp_ssc);
    if (chk_l1)  check_val({name, "_lat1_busy"}, l_busy, 0);
    if (r.sf) begin
      exp_sc++;
      if (exp_ssc < 15) exp_ssc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    in_t  idle, md_in, ov_in, lw_in;
    exp_t zero_e, md_e;

    idle   = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    md_in  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    ov_in  = mk_in(1, 7, 0, 0, 7, 0, 0, 0, 1, 1, 0, 0);
    lw_in  = mk_in(1, 7, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0);
    zero_e = mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    md_e   = mk_exp(2'b00, 2'b00, 1, 1, 0, 0, 1, 1);

    tbl[0]  = '{"fwd_a_mem",   mk_in(1, 2, 5, 0, 3, 5, 5, 0, 0, 0, 1, 1), mk_exp(2'b10, 2'b00, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{"fwd_a_wb",    mk_in(1, 2, 5, 0, 3, 5, 5, 0, 0, 0, 0, 1), mk_exp(2'b01, 2'b00, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{"fwd_a_x0",    mk_in(1, 2, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{"fwd_b_mem",   mk_in(1, 2, 4, 9, 3, 9, 9, 0, 0, 0, 1, 1), mk_exp(2'b00, 2'b10, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{"fwd_b_wb",    mk_in(1, 2, 4, 9, 3, 3, 9, 0, 0, 0, 1, 1), mk_exp(2'b00, 2'b01, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{"fwd_b_none",  mk_in(1, 2, 4, 9, 3, 9, 1, 0, 0, 0, 0, 1), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{"fwd_both",    mk_in(1, 2, 5, 5, 3, 5, 0, 0, 0, 0, 1, 0), mk_exp(2'b10, 2'b10, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{"lduse_rs2",   mk_in(1, 7, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 1, 0, 0, 1, 0, 0)};
    tbl[8]  = '{"lduse_rs1",   mk_in(7, 2, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 1, 0, 0, 1, 0, 0)};
    tbl[9]  = '{"load_x0",     mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{"no_load",     mk_in(7, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{"branch",      mk_in(1, 2, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0), mk_exp(2'b00, 2'b00, 0, 0, 1, 1, 0, 0)};
    tbl[12] = '{"branch_ld",   mk_in(1, 7, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0), mk_exp(2'b00, 2'b00, 1, 0, 1, 1, 0, 0)};

    // Reset state with all inputs at zero.
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, PCSrcE, ResultSrcEb0, MdStartE,
     RegWriteM, RegWriteW} = idle;
    #1;
    check_val("rst_stallcount", StallCount, 0);
    check_val("rst_satcount", s_sc, 0);
    check_val("rst_outputs",
              {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 13; k++) apply(tbl[k].name, tbl[k].i, tbl[k].e);

    // One multi-cycle op, then two back-to-back ops.
    chk_l1 = 1;
    for (int k = 0; k < 4; k++) apply("md_single", md_in, (k < 3) ? md_e : zero_e);
    for (int k = 0; k < 8; k++) apply("md_b2b", md_in, ((k % 4) == 3) ? zero_e : md_e);
    chk_l1 = 0;
    apply("idle", idle, zero_e);

    // Load-use in decode during a multi-cycle stall.
    for (int k = 0; k < 3; k++) apply("md_overlap", ov_in, md_e);
    apply("md_overlap_rel", ov_in, mk_exp(2'b00, 2'b00, 1, 0, 0, 1, 0, 0));
    apply("idle", idle, zero_e);

    // Branch during a multi-cycle op clears the count.
    apply("md_pre_br", md_in, md_e);
    apply("md_pre_br", md_in, md_e);
    apply("md_br", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0),
          mk_exp(2'b00, 2'b00, 1, 1, 1, 1, 1, 1));
    for (int k = 0; k < 4; k++) apply("md_after_br", md_in, (k < 3) ? md_e : zero_e);
    apply("idle", idle, zero_e);

    // Asynchronous reset mid-op, with MdStartE still high afterwards.
    apply("md_pre_rst", md_in, md_e);
    apply("md_pre_rst", md_in, md_e);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_cnt", StallCount, 0);
    check_val("async_rst_satcnt", s_sc, 0);
    check_val("async_rst_busy", MdBusy, 1);
    @(posedge clk);
    #1;
    check_val("rst_hold_cnt", StallCount, 0);
    reset = 1'b0;
    exp_sc = 0;
    exp_ssc = 0;
    for (int k = 0; k < 4; k++) apply("md_after_rst", md_in, (k < 3) ? md_e : zero_e);
    apply("idle", idle, zero_e);

    // Saturation of the 4-bit counter instance.
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_sc = 0;
    exp_ssc = 0;
    chk_sat = 1;
    for (int k = 0; k < 20; k++) apply("sat", lw_in, mk_exp(2'b00, 2'b00, 1, 0, 0, 1, 0, 0));
    apply("sat_idle", idle, zero_e);
    chk_sat = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 The block SHALL have a parameter REG_AW, default 5, giving the register-address width.
REQ-002 The block SHALL have a parameter MD_LAT, default 4, giving the EX-stage occupancy in cycles of a multi-cycle (mul/div) op; legal range 1..16.
REQ-003 The block SHALL have a parameter CNT_W, default 32, giving the stall-counter width.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Rs1D, Rs2D  in  REG_AW  source registers in decode.
- Rs1E, Rs2E, RdE  in  REG_AW  sources and destination in execute.
- RdM, RdW  in  REG_AW  destinations in memory and writeback.
- PCSrcE  in  1  taken branch or jump in EX.
- ResultSrcEb0  in  1  load in EX.
- MdStartE  in  1  multi-cycle op in EX.
- RegWriteM, RegWriteW  in  1  register-write enables.
- ForwardAE, ForwardBE  out  2  ALU operand select.
- StallF, StallD, StallE  out  1  hold PC, IF/ID and ID/EX.
- FlushD, FlushE, FlushM  out  1  bubble into ID, EX and MEM.
- MdBusy  out  1  multi-cycle op is holding EX.
- StallCount  out  CNT_W  cycles with StallF high.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-006 Forwarding SHALL be combinational, with encodings 00 = register file, 10 = MEM, 01 = WB.
REQ-007 ForwardAE SHALL be 10 if Rs1E!=0 & Rs1E==RdM & RegWriteM; otherwise 01 if Rs1E!=0 & Rs1E==RdW & RegWriteW; otherwise 00. MEM SHALL win over WB. ForwardBE SHALL follow the same rule using Rs2E.
REQ-008 lwStall SHALL equal ResultSrcEb0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE); a load to x0 SHALL never stall.
REQ-009 A counter mdcnt of width clog2(MD_LAT)+1 SHALL track multi-cycle occupancy.
REQ-010 mdStall SHALL equal MdStartE & (mdcnt != MD_LAT-1); MdBusy SHALL equal mdStall.
REQ-011 mdcnt update at each clk edge:
- if PCSrcE, mdcnt <= 0;
- else if mdStall, mdcnt <= mdcnt+1;
- else mdcnt <= 0.
REQ-012 A multi-cycle op SHALL therefore occupy EX for exactly MD_LAT cycles: MD_LAT-1 stalled cycles plus one release cycle. MD_LAT=1 SHALL never stall.
REQ-013 While mdStall is high: StallF=StallD=StallE=1, FlushM=1 (bubble into MEM), FlushE=0.
REQ-014 While mdStall is low: StallE=0, FlushM=0.
REQ-015 StallF = StallD = lwStall | mdStall.
REQ-016 FlushD SHALL equal PCSrcE.
REQ-017 FlushE SHALL equal (lwStall & ~mdStall) | PCSrcE. A load-use hazard during a multi-cycle stall SHALL NOT flush EX; it re-evaluates after release.
REQ-018 PCSrcE and MdStartE SHALL be mutually exclusive by construction. If both are high, PCSrcE SHALL win: mdcnt clears next edge, and stall outputs still follow REQ-015.
REQ-019 Back-to-back multi-cycle ops (MdStartE high in the release cycle, then the next op enters EX) SHALL restart counting from 0 with no lost or extra cycle.
REQ-020 StallCount SHALL increment by 1 at each clk edge where StallF=1 and saturate at all-ones (no wrap).

Reset
REQ-021 reset high SHALL force mdcnt=0 and StallCount=0 immediately, independent of clk.
REQ-022 With reset high, outputs SHALL remain combinational functions of inputs with mdcnt=0. Asserting reset mid multi-cycle op SHALL abort the count; after reset, a still-high MdStartE SHALL restart at mdcnt=0.
REQ-023 No output SHALL be X after reset with all inputs known.

Verification
REQ-024 Forward priority: Rs1E=5, RdM=5, RdW=5, RegWriteM=RegWriteW=1 -> ForwardAE=10; drop RegWriteM -> 01; Rs1E=0 -> 00.
REQ-025 Load-use: ResultSrcEb0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallCount+1; repeat with RdE=0 -> no stall.
REQ-026 Multi-cycle, MD_LAT=4: MdStartE held high -> MdBusy/StallE/FlushM high for 3 cycles, low on the 4th; StallCount increases by 3.
REQ-027 Overlap: load-use hazard in decode during an MD stall -> FlushE stays 0 throughout MD stall; FlushE=1 in the release cycle.
REQ-028 Reset mid-op: assert reset asynchronously at mdcnt=2 -> mdcnt and StallCount read 0 before the next clk edge; op restarts with a full MD_LAT-1 stall after deassertion.
REQ-029 Saturation: CNT_W=4, StallF held high for 20 cycles -> StallCount reaches 15 and holds.
